// File: rtl/line_sq_diff_summer.sv
// Sums (pix_a - pix_b)^2 over LINE_SIZE accepted pixel pairs and emits one registered line sum.
// Define LINE_SUM_ERR_EN to add the sticky err output (restart seen while a line is in progress).
module line_sq_diff_summer #(
    parameter int unsigned PIXEL_SIZE = 8,
    parameter int unsigned LINE_SIZE  = 640
) (
    input  logic                                      CLK,
    input  logic                                      resetN,
    input  logic                                      pix_valid,
    input  logic [PIXEL_SIZE-1:0]                     pix_a,
    input  logic [PIXEL_SIZE-1:0]                     pix_b,
    input  logic                                      line_restart,
    output logic [$clog2(LINE_SIZE)+2*PIXEL_SIZE-1:0] line_sum,
`ifdef LINE_SUM_ERR_EN
    output logic                                      err,
`endif
    output logic                                      line_sum_valid
);

    localparam int unsigned CNT_W = $clog2(LINE_SIZE);
    localparam int unsigned SQ_W  = 2 * PIXEL_SIZE;
    localparam int unsigned SUM_W = CNT_W + SQ_W;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic                  accept;

    logic [CNT_W-1:0]      pix_cnt_q, pix_cnt_d;

    logic [PIXEL_SIZE-1:0] s0_a_q, s0_a_d;
    logic [PIXEL_SIZE-1:0] s0_b_q, s0_b_d;
    logic                  s0_valid_q, s0_valid_d;
    logic                  s0_last_q, s0_last_d;

    logic [PIXEL_SIZE-1:0] s1_diff_q, s1_diff_d;
    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_last_q, s1_last_d;

    logic [SQ_W-1:0]       s2_sq_q, s2_sq_d;
    logic                  s2_valid_q, s2_valid_d;
    logic                  s2_last_q, s2_last_d;

    logic [SUM_W-1:0]      acc_q, acc_d;
    logic [SUM_W-1:0]      line_sum_q, line_sum_d;
    logic                  line_sum_valid_q, line_sum_valid_d;

    assign accept = pix_valid & ~line_restart;

    always_comb begin
        pix_cnt_d        = pix_cnt_q;
        s0_a_d           = s0_a_q;
        s0_b_d           = s0_b_q;
        s0_valid_d       = 1'b0;
        s0_last_d        = 1'b0;
        s1_diff_d        = (s0_a_q >= s0_b_q) ? (s0_a_q - s0_b_q) : (s0_b_q - s0_a_q);
        s1_valid_d       = 1'b0;
        s1_last_d        = 1'b0;
        s2_sq_d          = SQ_W'(s1_diff_q) * SQ_W'(s1_diff_q);
        s2_valid_d       = 1'b0;
        s2_last_d        = 1'b0;
        acc_d            = acc_q;
        line_sum_d       = line_sum_q;
        line_sum_valid_d = 1'b0;

        if (line_restart) begin
            // Abort drops every in-flight pair, including a last-tagged one.
            pix_cnt_d = '0;
            acc_d     = '0;
        end else begin
            if (accept) begin
                s0_a_d     = pix_a;
                s0_b_d     = pix_b;
                s0_valid_d = 1'b1;
                s0_last_d  = (pix_cnt_q == LAST_CNT);
                pix_cnt_d  = (pix_cnt_q == LAST_CNT) ? '0 : pix_cnt_q + CNT_ONE;
            end

            s1_valid_d = s0_valid_q;
            s1_last_d  = s0_valid_q & s0_last_q;
            s2_valid_d = s1_valid_q;
            s2_last_d  = s1_valid_q & s1_last_q;

            if (s2_valid_q) begin
                if (s2_last_q) begin
                    line_sum_d       = acc_q + SUM_W'(s2_sq_q);
                    line_sum_valid_d = 1'b1;
                    acc_d            = '0;
                end else begin
                    acc_d = acc_q + SUM_W'(s2_sq_q);
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge resetN) begin
        if (!resetN) begin
            pix_cnt_q        <= '0;
            s0_a_q           <= '0;
            s0_b_q           <= '0;
            s0_valid_q       <= 1'b0;
            s0_last_q        <= 1'b0;
            s1_diff_q        <= '0;
            s1_valid_q       <= 1'b0;
            s1_last_q        <= 1'b0;
            s2_sq_q          <= '0;
            s2_valid_q       <= 1'b0;
            s2_last_q        <= 1'b0;
            acc_q            <= '0;
            line_sum_q       <= '0;
            line_sum_valid_q <= 1'b0;
        end else begin
            pix_cnt_q        <= pix_cnt_d;
            s0_a_q           <= s0_a_d;
            s0_b_q           <= s0_b_d;
            s0_valid_q       <= s0_valid_d;
            s0_last_q        <= s0_last_d;
            s1_diff_q        <= s1_diff_d;
            s1_valid_q       <= s1_valid_d;
            s1_last_q        <= s1_last_d;
            s2_sq_q          <= s2_sq_d;
            s2_valid_q       <= s2_valid_d;
            s2_last_q        <= s2_last_d;
            acc_q            <= acc_d;
            line_sum_q       <= line_sum_d;
            line_sum_valid_q <= line_sum_valid_d;
        end
    end

    assign line_sum       = line_sum_q;
    assign line_sum_valid = line_sum_valid_q;

`ifdef LINE_SUM_ERR_EN
    typedef enum logic [0:0] {StIdle, StActive} state_e;

    state_e state_q, state_d;
    logic   err_q, err_d;
    logic   line_done;

    assign line_done = s2_valid_q & s2_last_q;

    always_ff @(posedge CLK or negedge resetN) begin
        if (!resetN) begin
            state_q <= StIdle;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StActive;
                end
            end
            StActive: begin
                // Idle only once the emitted line leaves nothing of a newer line behind it.
                if (line_restart) begin
                    state_d = StIdle;
                end else if (line_done && !accept && !s0_valid_q && !s1_valid_q &&
                             (pix_cnt_q == '0)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        err_d = err_q | (line_restart & (state_q == StActive));
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_line_sq_diff_summer.sv
// Self-checking bench for line_sq_diff_summer (PIXEL_SIZE=8, LINE_SIZE=4) using a scoreboard queue
// filled from the driven stimulus and drained whenever the DUT strobes a line sum.
module tb_line_sq_diff_summer;

    localparam int unsigned PIXEL_SIZE = 8;
    localparam int unsigned LINE_SIZE  = 4;
    localparam int unsigned SUM_W      = $clog2(LINE_SIZE) + 2 * PIXEL_SIZE;

    logic                  CLK = 1'b0;
    logic                  resetN;
    logic                  pix_valid;
    logic [PIXEL_SIZE-1:0] pix_a;
    logic [PIXEL_SIZE-1:0] pix_b;
    logic                  line_restart;
    logic [SUM_W-1:0]      line_sum;
    logic                  line_sum_valid;
`ifdef LINE_SUM_ERR_EN
    logic                  err;
`endif

    line_sq_diff_summer #(
        .PIXEL_SIZE (PIXEL_SIZE),
        .LINE_SIZE  (LINE_SIZE)
    ) dut (
        .CLK            (CLK),
        .resetN         (resetN),
        .pix_valid      (pix_valid),
        .pix_a          (pix_a),
        .pix_b          (pix_b),
        .line_restart   (line_restart),
        .line_sum       (line_sum),
`ifdef LINE_SUM_ERR_EN
        .err            (err),
`endif
        .line_sum_valid (line_sum_valid)
    );

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int unsigned       checks  = 0;
    int unsigned       errors  = 0;
    int unsigned       strobes = 0;
    int unsigned       last_strobe_cyc = 0;
    int unsigned       strobes_before;
    logic              prev_valid = 1'b0;

    int unsigned       m_cnt = 0;
    longint unsigned   m_acc = 0;
    longint unsigned   exp_sum_q[$];
    int unsigned       exp_cyc_q[$];

    task automatic check_val(input string tag, input longint unsigned got,
                             input longint unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_cnt = 0;
        m_acc = 0;
        exp_sum_q.delete();
        exp_cyc_q.delete();
    endtask

    // Runs at negedge+1, after any strobe for the previous edge has settled.
    task automatic observe();
        if (line_sum_valid) begin
            check_val("no_consecutive_strobe", prev_valid, 0);
            if (strobes != 0) begin
                check_val("strobe_spacing", (cyc - last_strobe_cyc) >= LINE_SIZE, 1);
            end
            if (exp_sum_q.size() == 0) begin
                check_val("unexpected_strobe", line_sum_valid, 0);
            end else begin
                check_val("line_sum", line_sum, exp_sum_q.pop_front());
                check_val("strobe_latency", cyc, exp_cyc_q.pop_front());
            end
            strobes++;
            last_strobe_cyc = cyc;
        end
        prev_valid = line_sum_valid;
    endtask

    task automatic drive(input logic v, input logic [PIXEL_SIZE-1:0] a,
                         input logic [PIXEL_SIZE-1:0] b, input logic rs);
        int unsigned d;
        @(negedge CLK);
        #1;
        observe();
        pix_valid    = v;
        pix_a        = a;
        pix_b        = b;
        line_restart = rs;
        if (rs) begin
            model_clear();
        end else if (v) begin
            d = (a > b) ? int'(a - b) : int'(b - a);
            m_acc += longint'(d * d);
            if (m_cnt == LINE_SIZE - 1) begin
                // Accepted on edge cyc+1, so the strobe follows edge cyc+4.
                exp_sum_q.push_back(m_acc);
                exp_cyc_q.push_back(cyc + 4);
                m_acc = 0;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0);
    endtask

    task automatic send_line(input logic [LINE_SIZE*PIXEL_SIZE-1:0] a_vec,
                             input logic [LINE_SIZE*PIXEL_SIZE-1:0] b_vec, input bit gaps);
        for (int i = 0; i < LINE_SIZE; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) idle();
            end
            drive(1'b1, a_vec[(LINE_SIZE-1-i)*PIXEL_SIZE +: PIXEL_SIZE],
                  b_vec[(LINE_SIZE-1-i)*PIXEL_SIZE +: PIXEL_SIZE], 1'b0);
        end
    endtask

    task automatic drain(input string tag);
        int unsigned n = 0;
        idle();
        while (exp_sum_q.size() != 0 && n < 20) begin
            idle();
            n++;
        end
        check_val(tag, exp_sum_q.size(), 0);
        repeat (2) idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetN       = 1'b0;
        pix_valid    = 1'b0;
        pix_a        = '0;
        pix_b        = '0;
        line_restart = 1'b0;
        #1;
        check_val("reset_line_sum", line_sum, 0);
        check_val("reset_valid", line_sum_valid, 0);
`ifdef LINE_SUM_ERR_EN
        check_val("reset_err", err, 0);
`endif
        repeat (3) @(negedge CLK);
        check_val("reset_line_sum_held", line_sum, 0);
        resetN = 1'b1;

        // Single line: 9 + 0 + 65025 + 0.
        send_line({8'd10, 8'd0, 8'd255, 8'd7}, {8'd7, 8'd0, 8'd0, 8'd7}, 1'b0);
        drain("single_drain");
        check_val("single_held", line_sum, 65034);
        check_val("single_strobes", strobes, 1);

        // Full-scale difference in both directions.
        send_line({4{8'd255}}, {4{8'd0}}, 1'b0);
        drain("max_ab_drain");
        check_val("max_ab_held", line_sum, 260100);
        send_line({4{8'd0}}, {4{8'd255}}, 1'b0);
        drain("max_ba_drain");
        check_val("max_ba_held", line_sum, 260100);

        // Back-to-back lines, second one with random gaps.
        send_line({4{8'd1}}, {4{8'd0}}, 1'b0);
        send_line({4{8'd2}}, {4{8'd0}}, 1'b1);
        drain("b2b_drain");
        check_val("b2b_held", line_sum, 16);

        // Sustained rate: three contiguous lines.
        strobes_before = strobes;
        send_line({4{8'd3}}, {4{8'd1}}, 1'b0);
        send_line({4{8'd5}}, {4{8'd1}}, 1'b0);
        send_line({4{8'd3}}, {4{8'd1}}, 1'b0);
        drain("sustained_drain");
        check_val("sustained_strobes", strobes - strobes_before, 3);
        check_val("sustained_held", line_sum, 16);

        // Restart while idle must not flag an error.
        drive(1'b0, '0, '0, 1'b1);
        idle();
`ifdef LINE_SUM_ERR_EN
        check_val("idle_restart_err", err, 0);
`endif

        // Restart mid-line with a valid pair in the same cycle.
        strobes_before = strobes;
        drive(1'b1, 8'd5, 8'd0, 1'b0);
        drive(1'b1, 8'd5, 8'd0, 1'b0);
        drive(1'b1, 8'd9, 8'd0, 1'b1);
        send_line({8'd1, 8'd2, 8'd3, 8'd4}, {4{8'd0}}, 1'b0);
        drain("restart_mid_drain");
        check_val("restart_mid_strobes", strobes - strobes_before, 1);
        check_val("restart_mid_held", line_sum, 30);
`ifdef LINE_SUM_ERR_EN
        check_val("restart_mid_err", err, 1);
`endif

        // Restart one cycle after the last accept: no strobe, old sum kept.
        strobes_before = strobes;
        send_line({4{8'd6}}, {4{8'd0}}, 1'b0);
        drive(1'b0, '0, '0, 1'b1);
        repeat (6) idle();
        check_val("restart_last_strobes", strobes - strobes_before, 0);
        check_val("restart_last_held", line_sum, 30);
`ifdef LINE_SUM_ERR_EN
        check_val("restart_last_err", err, 1);
`endif

        // Asynchronous reset mid-line clears outputs without waiting for a clock edge.
        drive(1'b1, 8'd10, 8'd3, 1'b0);
        drive(1'b1, 8'd10, 8'd3, 1'b0);
        @(negedge CLK);
        #2;
        pix_valid = 1'b0;
        resetN    = 1'b0;
        #1;
        check_val("async_reset_line_sum", line_sum, 0);
        check_val("async_reset_valid", line_sum_valid, 0);
`ifdef LINE_SUM_ERR_EN
        check_val("async_reset_err", err, 0);
`endif
        model_clear();
        @(negedge CLK);
        #1;
        resetN     = 1'b1;
        prev_valid = 1'b0;
        send_line({4{8'd10}}, {4{8'd3}}, 1'b0);
        drain("after_reset_drain");
        check_val("after_reset_held", line_sum, 196);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
